// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch FSM states (HALT only when FETCH_FAULT_EN is defined)
//   fetch_entry_t : one fetch-queue entry {pc, instr}
//   NOP_INSTR     : word presented to decode while the queue is empty
// Optional feature macro: FETCH_FAULT_EN
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
`ifdef FETCH_FAULT_EN
    , HALT
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bus bundle of the fetch stage.
//   imem_*     : single-outstanding instruction memory request/ack
//   redirect*  : branch/jump re-steer from execute
//   dec_*      : valid/ready head-of-queue presentation to decode
//   fetch_fault: misaligned-redirect flag (only with FETCH_FAULT_EN)
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pcplus4;
`ifdef FETCH_FAULT_EN
  logic        fetch_fault;
`endif

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus4,
`ifdef FETCH_FAULT_EN
    output fetch_fault,
`endif
    input  imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus4,
`ifdef FETCH_FAULT_EN
    input  fetch_fault,
`endif
    output imem_ack, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch_entry_t.
//   push/wdata : enqueue (ignored when full and not popping)
//   pop/rdata  : dequeue head (ignored when empty); rdata is the head entry
//   flush      : clears the queue, dominates push and pop
//   count      : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~flush & (count_q != '0);
    do_push  = push & ~flush & ((count_q != CW'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk, reset_n : core clock, async active-low reset
//   bus          : fetch_if.master (imem request/ack, redirect, decode handshake)
// Keeps one memory request outstanding, buffers returned words in a
// QDEPTH-entry queue and presents the head as {instr, pc, pc+4} to decode.
// A redirect flushes the queue; a request still in flight is completed
// in DROP and its data thrown away.
// Optional feature macro: FETCH_FAULT_EN (misaligned redirect -> sticky
// fetch_fault and HALT); without it redirect_pc[1:0] is ignored.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic clk,
  input  logic reset_n,
  fetch_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;   // address of the request being dropped
  logic [CW-1:0] count, count_next;
  fetch_entry_t  head;
  logic          dec_valid, push, pop, req;
`ifdef FETCH_FAULT_EN
  logic          fault_q, fault_d;
`endif

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (bus.redirect),
    .push    (push),
    .pop     (pop),
    .wdata   ('{pc: fpc_q, instr: bus.imem_rdata}),
    .rdata   (head),
    .count   (count)
  );

  always_comb begin
    dec_valid   = (count != '0);
    pop         = dec_valid & bus.dec_ready & ~bus.redirect;
    push        = bus.imem_ack & (state_q == FETCH);
    count_next  = count + CW'(push) - CW'(pop);
    state_d     = state_q;
    fpc_d       = fpc_q;
    drop_addr_d = drop_addr_q;
    req         = 1'b0;
`ifdef FETCH_FAULT_EN
    fault_d     = fault_q;
`endif

    unique case (state_q)
      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          fpc_d   = fpc_q + 32'd4;
          state_d = (count_next < CW'(QDEPTH)) ? FETCH : HOLD;
        end
      end
      HOLD: if (pop) state_d = FETCH;
      DROP: begin
        req = 1'b1;
`ifdef FETCH_FAULT_EN
        if (bus.imem_ack) state_d = fault_q ? HALT : FETCH;
`else
        if (bus.imem_ack) state_d = FETCH;
`endif
      end
`ifdef FETCH_FAULT_EN
      HALT: ;
`endif
      default: state_d = FETCH;
    endcase

    if (bus.redirect) begin
      fpc_d = align_pc(bus.redirect_pc);
      unique case (state_q)
        FETCH: begin
          state_d = bus.imem_ack ? FETCH : DROP;
          if (!bus.imem_ack) drop_addr_d = fpc_q;
        end
        HOLD:  state_d = FETCH;
        // An ack arriving with the redirect completes the stale request,
        // so nothing remains to drop.
        DROP:  state_d = bus.imem_ack ? FETCH : DROP;
`ifdef FETCH_FAULT_EN
        HALT:  state_d = HALT;
`endif
        default: state_d = FETCH;
      endcase
`ifdef FETCH_FAULT_EN
      if (bus.redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
      // Once faulted, never fetch again; an in-flight request still drains via DROP.
      if ((fault_d || fault_q) && state_d == FETCH) state_d = HALT;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      fpc_q       <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end
  assign bus.fetch_fault = fault_q;
`endif

  // Reset state is FETCH, so the request is gated off while reset is held.
  assign bus.imem_req    = req & reset_n;
  assign bus.imem_addr   = (state_q == DROP) ? drop_addr_q : fpc_q;
  assign bus.dec_valid   = dec_valid;
  assign bus.dec_instr   = dec_valid ? head.instr : NOP_INSTR;
  assign bus.dec_pc      = dec_valid ? head.pc : 32'd0;
  assign bus.dec_pcplus4 = dec_valid ? head.pc + 32'd4 : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural
// instruction memory (ack after 'lat' wait cycles, data = f(addr)).
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   lat;
  int   mwait;
  int   n_chk = 0;
  int   n_fail = 0;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            mwait <= 0;
    else if (bus.imem_req && !bus.imem_ack)  mwait <= mwait + 1;
    else                                     mwait <= 0;
  end

  always_comb begin
    bus.imem_ack   = bus.imem_req && (mwait >= lat);
    bus.imem_rdata = mem_word(bus.imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n         = 1'b0;
    lat             = 0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dec_ready   = 1'b1;

    // reset values
    repeat (2) nxt();
    #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_instr", bus.dec_instr, NOP_INSTR);
    chk("rst_pc",    bus.dec_pc, 32'd0);
    chk("rst_pc4",   bus.dec_pcplus4, 32'd0);
`ifdef FETCH_FAULT_EN
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
`endif

    // zero-wait streaming; empty queue with dec_ready must not underflow
    reset_n = 1'b1;
    #1;
    chk("c0_req",   32'(bus.imem_req), 32'd1);
    chk("c0_addr",  bus.imem_addr, 32'h0);
    chk("c0_valid", 32'(bus.dec_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      nxt(); #1;
      chk("str_addr",  bus.imem_addr, 32'(4*k));
      chk("str_valid", 32'(bus.dec_valid), 32'd1);
      chk("str_pc",    bus.dec_pc, 32'(4*(k-1)));
      chk("str_pc4",   bus.dec_pcplus4, 32'(4*k));
      chk("str_instr", bus.dec_instr, mem_word(32'(4*(k-1))));
    end

    // redirect together with ack and pop
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    nxt();
    bus.redirect  = 1'b0;
    bus.dec_ready = 1'b0;
    #1;
    chk("rdr_valid", 32'(bus.dec_valid), 32'd0);
    chk("rdr_addr",  bus.imem_addr, 32'h200);

    // decode stall: two pushes then request drops
    nxt(); #1;
    chk("stl_pc",   bus.dec_pc, 32'h200);
    chk("stl_addr", bus.imem_addr, 32'h204);
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk("stl_req0", 32'(bus.imem_req), 32'd0);
      chk("stl_hpc",  bus.dec_pc, 32'h200);
    end
    nxt();
    bus.dec_ready = 1'b1;
    #1;
    chk("pop_req0", 32'(bus.imem_req), 32'd0);
    chk("pop_pc0",  bus.dec_pc, 32'h200);
    nxt(); #1;
    chk("res_req",  32'(bus.imem_req), 32'd1);
    chk("res_addr", bus.imem_addr, 32'h208);
    chk("res_pc1",  bus.dec_pc, 32'h204);
    nxt(); #1;
    chk("res_pc2",  bus.dec_pc, 32'h208);
    chk("res_addr2", bus.imem_addr, 32'h20C);

    // async reset mid-transfer, then 3-cycle memory
    nxt();
    reset_n = 1'b0;
    lat     = 2;
    #1;
    chk("mrst_req",   32'(bus.imem_req), 32'd0);
    chk("mrst_valid", 32'(bus.dec_valid), 32'd0);
    nxt();
    reset_n = 1'b1;
    #1;
    chk("l_c0_addr", bus.imem_addr, 32'h0);
    chk("l_c0_ack",  32'(bus.imem_ack), 32'd0);
    nxt();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    chk("l_c1_addr", bus.imem_addr, 32'h0);
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("l_c2_addr", bus.imem_addr, 32'h0);
    chk("l_c2_ack",  32'(bus.imem_ack), 32'd1);
    chk("l_c2_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("l_c3_addr", bus.imem_addr, 32'h100);
    chk("l_c3_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("l_c4_addr", bus.imem_addr, 32'h100);
    nxt(); #1;
    chk("l_c5_ack",  32'(bus.imem_ack), 32'd1);
    chk("l_c5_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("l_c6_valid", 32'(bus.dec_valid), 32'd1);
    chk("l_c6_pc",    bus.dec_pc, 32'h100);
    chk("l_c6_instr", bus.dec_instr, mem_word(32'h100));
    chk("l_c6_addr",  bus.imem_addr, 32'h104);

    // PC wrap at top of address space
    lat             = 0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    nxt();
    bus.redirect = 1'b0;
    #1;
    chk("wr_addr",  bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("wr_pc",   bus.dec_pc, 32'hFFFF_FFFC);
    chk("wr_pc4",  bus.dec_pcplus4, 32'h0);
    chk("wr_next", bus.imem_addr, 32'h0);

    // misaligned redirect
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h102;
    nxt();
    bus.redirect = 1'b0;
    #1;
`ifdef FETCH_FAULT_EN
    chk("flt_fault", 32'(bus.fetch_fault), 32'd1);
    chk("flt_req",   32'(bus.imem_req), 32'd0);
    chk("flt_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("flt_req2",   32'(bus.imem_req), 32'd0);
    chk("flt_fault2", 32'(bus.fetch_fault), 32'd1);
    chk("flt_valid2", 32'(bus.dec_valid), 32'd0);
`else
    chk("msk_addr",  bus.imem_addr, 32'h100);
    chk("msk_valid", 32'(bus.dec_valid), 32'd0);
    nxt(); #1;
    chk("msk_pc",    bus.dec_pc, 32'h100);
    chk("msk_addr2", bus.imem_addr, 32'h104);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
